sdram_ctrl_module: RTL

- Top-level sequencer for the SDRAM path. It runs power-up initialisation once, then schedules periodic auto-refresh and user write/read bursts.
- It drives the Start/Done handshakes of the init, auto-refresh, write and read sub-modules.
- It outputs a select code that the top-level uses to mux SDRAM_CMD/SDRAM_BA from the active sub-module.
- Priority: refresh > write > read.

---
 rtl/sdram_ctrl_module.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sdram_ctrl_module.sv
// sdram_ctrl_module
// Top-level SDRAM sequencer. After reset it runs the init sub-module once,
// then arbitrates between periodic auto-refresh and user write/read bursts
// (priority: refresh > write > read) and reports which sub-module owns the
// SDRAM command bus through Sel.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   WrEN_Sig        user write request (level, held until Done_Sig)
//   RdEN_Sig        user read request  (level, held until Done_Sig)
//   Done_Sig        one-cycle pulse: granted write/read burst finished
//   Busy_Sig        high whenever the sequencer is not idle
//   Init_Start_Sig / Init_Done_Sig   init sub-module handshake
//   AR_Start_Sig   / AR_Done_Sig     auto-refresh sub-module handshake
//   WR_Start_Sig   / WR_Done_Sig     write sub-module handshake
//   RD_Start_Sig   / RD_Done_Sig     read sub-module handshake
//   Sel             command-mux select: 0 init, 1 refresh, 2 write, 3 read
//   Ref_Miss_Sig    (only with SDRAM_REFRESH_MISS_EN) sticky missed-refresh flag
//
// Handshake: a Start output is held high for as long as its state is active.
// The matching Done is a one-cycle pulse; the edge that samples it moves the
// FSM on and drops Start on that same edge, so a self-restarting sub-module
// never sees Start still high afterwards. Done pulses from sub-modules that
// are not active are ignored.
//
// Optional feature macro: SDRAM_REFRESH_MISS_EN
module sdram_ctrl_module #(
    parameter logic [10:0] T15US = 11'd1500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WrEN_Sig,
    input  logic       RdEN_Sig,
    output logic       Done_Sig,
    output logic       Busy_Sig,
    output logic       Init_Start_Sig,
    input  logic       Init_Done_Sig,
    output logic       AR_Start_Sig,
    input  logic       AR_Done_Sig,
    output logic       WR_Start_Sig,
    input  logic       WR_Done_Sig,
    output logic       RD_Start_Sig,
    input  logic       RD_Done_Sig,
    output logic [1:0] Sel
`ifdef SDRAM_REFRESH_MISS_EN
    ,
    output logic       Ref_Miss_Sig
`endif
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_AREF   = 3'd2,
        S_WRITE  = 3'd3,
        S_READ   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_c1;
    logic        r_ref_pend;
    logic        w_expire;
    logic        r_init_start;
    logic        r_ar_start;
    logic        r_wr_start;
    logic        r_rd_start;
    logic        r_done;
    logic        r_busy;
    logic [1:0]  r_sel;
`ifdef SDRAM_REFRESH_MISS_EN
    logic        r_ref_miss;
`endif

    // Next-state logic; the IDLE decision uses the registered Ref_Pend, so an
    // expiry on the decision edge is only seen at the following IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   if (Init_Done_Sig) w_next = S_IDLE;
            S_IDLE: begin
                if (r_ref_pend)    w_next = S_AREF;
                else if (WrEN_Sig) w_next = S_WRITE;
                else if (RdEN_Sig) w_next = S_READ;
            end
            S_AREF:   if (AR_Done_Sig) w_next = S_IDLE;
            S_WRITE:  if (WR_Done_Sig) w_next = S_FINISH;
            S_READ:   if (RD_Done_Sig) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_INIT;
        endcase
    end

    // The refresh timer is frozen at zero while initialising.
    assign w_expire = (r_state != S_INIT) && (r_c1 == (T15US - 11'd1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_INIT;
            r_c1         <= 11'd0;
            r_ref_pend   <= 1'b0;
            r_init_start <= 1'b0;
            r_ar_start   <= 1'b0;
            r_wr_start   <= 1'b0;
            r_rd_start   <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_sel        <= 2'd0;
`ifdef SDRAM_REFRESH_MISS_EN
            r_ref_miss   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;

            if (r_state == S_INIT || w_expire) r_c1 <= 11'd0;
            else                               r_c1 <= r_c1 + 11'd1;

            // Clearing on AREF entry beats a simultaneous expiry: that expiry
            // belongs to a period that is already pending, so it is dropped.
            if (r_state == S_IDLE && w_next == S_AREF) r_ref_pend <= 1'b0;
            else if (w_expire)                         r_ref_pend <= 1'b1;

            // Outputs are registered from the next state so they line up with
            // the state register.
            r_init_start <= (w_next == S_INIT);
            r_ar_start   <= (w_next == S_AREF);
            r_wr_start   <= (w_next == S_WRITE);
            r_rd_start   <= (w_next == S_READ);
            r_done       <= (w_next == S_FINISH);
            r_busy       <= (w_next != S_IDLE);

            // Sel only changes when a sub-module is granted; FINISH and IDLE
            // keep the last owner on the command mux.
            case (w_next)
                S_INIT:  r_sel <= 2'd0;
                S_AREF:  r_sel <= 2'd1;
                S_WRITE: r_sel <= 2'd2;
                S_READ:  r_sel <= 2'd3;
                default: r_sel <= r_sel;
            endcase

`ifdef SDRAM_REFRESH_MISS_EN
            if (w_expire && r_ref_pend) r_ref_miss <= 1'b1;
`endif
        end
    end

    assign Init_Start_Sig = r_init_start;
    assign AR_Start_Sig   = r_ar_start;
    assign WR_Start_Sig   = r_wr_start;
    assign RD_Start_Sig   = r_rd_start;
    assign Done_Sig       = r_done;
    assign Busy_Sig       = r_busy;
    assign Sel            = r_sel;
`ifdef SDRAM_REFRESH_MISS_EN
    assign Ref_Miss_Sig   = r_ref_miss;
`endif

endmodule
